// File: rtl/bcd_to_binary_param.sv
// Sequential BCD-to-binary converter (shift-right / subtract-3), DIGITS BCD digits in, BIN_W bits out.
// Optional input digit validation is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_param #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  St,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [BIN_W-1:0]      Binary
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ADJ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [BCD_W-1:0]   r_a;
    logic [BIN_W-1:0]   r_b;
    logic [BIN_W-1:0]   r_binary;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [BCD_W-1:0]   w_a_shift;
    logic [BCD_W-1:0]   w_a_adj;
    logic [BIN_W-1:0]   w_b_shift;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_bcd_bad;

    assign w_a_shift  = {1'b0, r_a[BCD_W-1:1]};
    assign w_b_shift  = {r_a[0], r_b[BIN_W-1:1]};
    assign w_cnt_next = r_cnt + CNT_W'(1);

    // Per-digit subtract-3 wraps inside the nibble; no borrow between digits.
    always_comb begin
        w_a_adj = r_a;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_a[4*i+3]) begin
                w_a_adj[4*i +: 4] = r_a[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_comb begin
        w_bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD[4*i +: 4] > 4'd9) begin
                w_bcd_bad = 1'b1;
            end
        end
    end
`else
    assign w_bcd_bad = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_binary <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (St) begin
                        if (w_bcd_bad) begin
                            // Rejected operand: report immediately, keep last result.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_a     <= BCD;
                            r_b     <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a   <= w_a_shift;
                    r_b   <= w_b_shift;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == CNT_LAST) begin
                        r_binary <= w_b_shift;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    r_a     <= w_a_adj;
                    r_state <= S_SHIFT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy   = r_busy;
    assign Done   = r_done;
    assign Err    = r_err;
    assign Binary = r_binary;

endmodule

// File: tb/tb_bcd_to_binary_param.sv
// Self-checking bench for bcd_to_binary_param: 3-digit and 4-digit instances,
// table vectors, hand sequences and random operands against a decimal reference.
module tb_bcd_to_binary_param;
    logic        clk;
    logic        rst;
    logic        st3, st4;
    logic [11:0] bcd3;
    logic [15:0] bcd4;
    logic        busy3, done3, err3;
    logic        busy4, done4, err4;
    logic [9:0]  bin3;
    logic [13:0] bin4;

    int total;
    int bad;
    int last3;
    int last4;

    bcd_to_binary_param #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .CLK(clk), .RST(rst), .St(st3), .BCD(bcd3),
        .Busy(busy3), .Done(done3), .Err(err3), .Binary(bin3)
    );

    bcd_to_binary_param #(.DIGITS(4), .BIN_W(14)) u_dut4 (
        .CLK(clk), .RST(rst), .St(st4), .BCD(bcd4),
        .Busy(busy4), .Done(done4), .Err(err4), .Binary(bin4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          exp;
    } vec_t;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int limit, input int hold_val,
                             input int poke, output int edges);
        logic d, b, b1;
        logic [31:0] v;
        bit hold_ok, excl_ok;
        edges = 0; hold_ok = 1; excl_ok = 1; d = 0; b1 = 0;
        while (!d && edges < limit) begin
            @(posedge clk); #1;
            edges++;
            if (sel == 0) begin d = done3; b = busy3; v = 32'(bin3); end
            else          begin d = done4; b = busy4; v = 32'(bin4); end
            if (edges == 1) b1 = b;
            if (b && d) excl_ok = 0;
            if (!d && v !== 32'(hold_val)) hold_ok = 0;
            if (poke > 0 && edges == poke) begin st4 = 1'b1; bcd4 = 16'h1234; end
            else if (poke > 0 && edges == poke + 1) st4 = 1'b0;
        end
        check("done_seen", 32'(d), 1);
        check("busy_after_accept", 32'(b1), 1);
        check("binary_hold", 32'(hold_ok), 1);
        check("busy_done_excl", 32'(excl_ok), 1);
    endtask

    task automatic conv3(input logic [11:0] bcd, input int exp_val, input string nm);
        int e;
        @(negedge clk); st3 = 1'b1; bcd3 = bcd;
        @(posedge clk); #1; st3 = 1'b0;
        wait_done(0, 60, last3, -1, e);
        check({nm, "_lat"}, 32'(e), 19);
        check({nm, "_bin"}, 32'(bin3), 32'(exp_val));
        check({nm, "_err"}, 32'(err3), 0);
        last3 = exp_val;
        @(posedge clk); #1;
        check({nm, "_done_fall"}, 32'(done3), 0);
    endtask

    task automatic conv4(input logic [15:0] bcd, input int exp_val, input int poke, input string nm);
        int e;
        @(negedge clk); st4 = 1'b1; bcd4 = bcd;
        @(posedge clk); #1; st4 = 1'b0;
        wait_done(1, 80, last4, poke, e);
        check({nm, "_lat"}, 32'(e), 27);
        check({nm, "_bin"}, 32'(bin4), 32'(exp_val));
        check({nm, "_err"}, 32'(err4), 0);
        last4 = exp_val;
        @(posedge clk); #1;
        check({nm, "_done_fall"}, 32'(done4), 0);
    endtask

    initial begin
        vec_t        tbl[8];
        int          e;
        int          v;
        logic [19:0] bb;

        total = 0; bad = 0; last3 = 0; last4 = 0;
        rst = 1'b1; st3 = 1'b0; st4 = 1'b0; bcd3 = '0; bcd4 = '0;

        tbl[0] = '{12'h001, 1};
        tbl[1] = '{12'h009, 9};
        tbl[2] = '{12'h010, 10};
        tbl[3] = '{12'h099, 99};
        tbl[4] = '{12'h100, 100};
        tbl[5] = '{12'h500, 500};
        tbl[6] = '{12'h998, 998};
        tbl[7] = '{12'h808, 808};

        #23 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Reset pulse while idle, between clock edges.
        #3 rst = 1'b1; #1;
        check("rst_busy", 32'(busy3), 0);
        check("rst_done", 32'(done3), 0);
        check("rst_err", 32'(err3), 0);
        check("rst_bin", 32'(bin3), 0);
        check("rst_bin4", 32'(bin4), 0);
        @(negedge clk); rst = 1'b0;

        conv3(12'h999, 999, "c999");
        conv3(12'h000, 0, "c000");
        conv3(12'h512, 512, "c512");

        conv4(16'h9999, 9999, 5, "d9999");
        conv4(16'h0001, 1, -1, "d0001");

        // Back-to-back: St held high across the DONE cycle.
        @(negedge clk); st3 = 1'b1; bcd3 = 12'h123;
        @(posedge clk); #1; bcd3 = 12'h456;
        wait_done(0, 60, last3, -1, e);
        check("b2b1_lat", 32'(e), 19);
        check("b2b1_bin", 32'(bin3), 123);
        last3 = 123;
        @(posedge clk); #1; st3 = 1'b0;
        check("b2b_no_idle", 32'(busy3), 1);
        wait_done(0, 60, last3, -1, e);
        check("b2b2_lat", 32'(e), 19);
        check("b2b2_bin", 32'(bin3), 456);
        last3 = 456;
        @(posedge clk); #1;

        // Asynchronous abort mid-conversion.
        @(negedge clk); st3 = 1'b1; bcd3 = 12'h999;
        @(posedge clk); #1; st3 = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1; #1;
        check("abort_busy", 32'(busy3), 0);
        check("abort_done", 32'(done3), 0);
        check("abort_bin", 32'(bin3), 0);
        @(negedge clk); rst = 1'b0;
        last3 = 0; last4 = 0;
        conv3(12'h042, 42, "c042");

        for (int i = 0; i < 8; i++) conv3(tbl[i].bcd, tbl[i].exp, "tbl");

        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 999);
            bb = to_bcd(v);
            conv3(bb[11:0], v, "rnd3");
        end
        for (int i = 0; i < 6; i++) begin
            v = $urandom_range(0, 9999);
            bb = to_bcd(v);
            conv4(bb[15:0], v, -1, "rnd4");
        end

        // Invalid digit operand.
`ifdef BCD2BIN_DIGIT_CHECK_EN
        @(negedge clk); st3 = 1'b1; bcd3 = 12'h9A1;
        @(posedge clk); #1; st3 = 1'b0;
        check("inv_done", 32'(done3), 1);
        check("inv_err", 32'(err3), 1);
        check("inv_busy", 32'(busy3), 0);
        check("inv_bin", 32'(bin3), 32'(last3));
        @(posedge clk); #1;
        check("inv_done_fall", 32'(done3), 0);
        check("inv_busy_after", 32'(busy3), 0);
        check("inv_err_fall", 32'(err3), 0);
`else
        @(negedge clk); st3 = 1'b1; bcd3 = 12'h9A1;
        @(posedge clk); #1; st3 = 1'b0;
        wait_done(0, 60, last3, -1, e);
        check("inv_lat", 32'(e), 19);
        check("inv_err", 32'(err3), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_param.md
# bcd_to_binary_param

Parametrised sequential BCD-to-binary converter using the shift-right / subtract-3 algorithm over a configurable number of BCD digits. It accepts a packed BCD word on a start strobe and shifts out one binary bit per SHIFT cycle. It presents the result on a registered output that holds until the next completed conversion. It sits between BCD entry/display logic and binary arithmetic datapaths, and adds asynchronous reset, a busy flag, back-to-back starts and optional digit validation.

## Interface
- DIGITS, default 3: number of BCD digits; legal 1..5.
- BIN_W, default 10: binary result width; must equal ceil(log2(10^DIGITS)), i.e. 4/7/10/14/17 for DIGITS 1..5.
- CLK, input, 1: single clock, rising edge.
- RST, input, 1: reset, asynchronous and active-high.
- St, input, 1: start strobe, sampled on the rising edge in IDLE or DONE.
- BCD, input, 4*DIGITS: packed BCD operand; digit i occupies bits [4i+3:4i]; captured on the accepting edge only.
- Busy, output, 1: high while in SHIFT or ADJ.
- Done, output, 1: one-cycle completion pulse, high only in DONE.
- Err, output, 1: invalid-digit flag, valid while Done=1.
- Binary, output, BIN_W: last converted result, registered.

## Operation
- Internal registers: A (4*DIGITS bits), B (BIN_W bits), counter (ceil(log2(BIN_W+1)) bits), and a 2-bit state.
- IDLE:
  - St=1: A<=BCD, B<=0, counter<=0, go to SHIFT.
  - St=0: stay in IDLE.
- SHIFT:
  - A<={1'b0,A[MSB:1]}, B<={A[0],B[BIN_W-1:1]}, counter<=counter+1.
  - If the new counter equals BIN_W: Binary<=the shifted B value, Done<=1, go to DONE.
  - Otherwise go to ADJ.
- ADJ: every digit of A whose bit 3 is set has 3 subtracted, modulo 16 per digit; no borrow crosses digits. Next state is SHIFT.
- DONE:
  - Done=1 for exactly one cycle.
  - St=1: accept a new operand exactly as IDLE does and go to SHIFT.
  - St=0: go to IDLE.
- St is ignored while Busy=1; an in-flight conversion is never restarted.
- Binary changes only on the completing SHIFT edge and holds through the following conversion.
- Arithmetic is unsigned. The result for valid BCD is always < 10^DIGITS, so it fits BIN_W exactly.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, Err 0, Binary 0, A 0, B 0, counter 0.
- An RST assertion mid-conversion aborts it immediately; Binary returns to 0.
- Latency:
  - St accepted at edge E0.
  - Edges E1..E(2*BIN_W-1) alternate SHIFT/ADJ: BIN_W shifts, BIN_W-1 adjusts.
  - Done and the new Binary value appear after edge E(2*BIN_W-1); this is edge 19 for BIN_W=10.
- Done falls on the next edge.
- Back-to-back: a St accepted in DONE starts the next conversion with no idle cycle, giving a throughput of 2*BIN_W cycles per conversion.
- Busy rises after E0 and falls after the final SHIFT edge; Busy and Done are never high together.

## Configuration
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - On the accepting edge, any BCD digit > 9 sends the block directly to DONE with Err<=1 and Binary unchanged.
  - Busy never asserts for that operand.
  - Valid operands produce Err=0.
- Undefined:
  - Err is tied to 0.
  - Invalid digits are converted by the same algorithm; the Binary value is unspecified but the latency is unchanged.

## Test plan
- DIGITS=3, BIN_W=10: RST pulse mid-idle -> all outputs 0. Then St with BCD=12'h999 -> Done pulse after edge 19, Binary=999 (10'h3E7), Err=0.
- BCD=12'h000 -> Binary=0 after 19 edges. Then BCD=12'h512 -> Binary=512, and Binary holds 0 throughout the second conversion.
- DIGITS=4, BIN_W=14: BCD=16'h9999 -> Binary=9999 (14'h270F), Done after edge 27. Pulsing St during Busy has no effect.
- Back-to-back: St held high, BCD=12'h123 then 12'h456 -> Done pulses 20 cycles apart, Binary=123 then 456.
- RST asserted asynchronously at cycle 7 of a conversion of 12'h999 -> immediate IDLE, Busy=0, Binary=0. The next St with 12'h042 -> Binary=42.
- With BCD2BIN_DIGIT_CHECK_EN: BCD=12'h9A1 -> Done and Err=1 one cycle after acceptance, Busy never high, Binary keeps its prior value. Without the macro: Err stays 0 and Done arrives after edge 19.
